// File: rtl/ysyx_22051013_mdu_pkg.sv
// Shared definitions for the ysyx_22051013 multiply/divide unit: RV M-extension
// funct3 codes, FSM state encoding, iteration counts, request payload and the
// operand-conditioning helpers used by the top level.
package ysyx_22051013_mdu_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned HLEN  = 32;
  localparam int unsigned CNT_W = 7;

  // Iteration counts for full-width and W-variant operations
  localparam logic [CNT_W-1:0] ITER_D = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] ITER_W = CNT_W'(HLEN);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  typedef struct packed {
    logic [2:0]      funct3;
    logic            word;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
  } mdu_req_t;

  // op1 is signed for MUL, MULH, MULHSU, DIV, REM
  function automatic logic op1_signed(input logic [2:0] f3);
    case (f3)
      F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM: return 1'b1;
      F3_MULHU, F3_DIVU, F3_REMU:                 return 1'b0;
      default:                                    return 1'b0;
    endcase
  endfunction

  // op2 is signed for MUL, MULH, DIV, REM
  function automatic logic op2_signed(input logic [2:0] f3);
    case (f3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [HLEN-1:0] x);
    return {{(XLEN-HLEN){x[HLEN-1]}}, x};
  endfunction

  // W-variants only look at the low word, extended according to signedness
  function automatic logic [XLEN-1:0] ext_op(input logic [XLEN-1:0] op,
                                             input logic sgn, input logic word);
    if (!word) return op;
    return sgn ? sext32(op[HLEN-1:0]) : {{(XLEN-HLEN){1'b0}}, op[HLEN-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? XLEN'(-x) : x;
  endfunction

endpackage

// File: rtl/ysyx_22051013_mdu_div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
// Ports: i_rem (partial remainder), i_bit (next dividend bit), i_divisor,
//        o_rem_c (next partial remainder), o_q_c (quotient bit).
module ysyx_22051013_div_iter
  import ysyx_22051013_mdu_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_bit,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem_c,
  output logic            o_q_c
);

  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  // When the divisor fits, the true difference is below the divisor, so the
  // low XLEN bits of a modular subtract are exact.
  assign w_diff  = w_shift[XLEN-1:0] - i_divisor;
  assign o_q_c   = w_shift >= {1'b0, i_divisor};
  assign o_rem_c = o_q_c ? w_diff : w_shift[XLEN-1:0];

endmodule

// File: rtl/ysyx_22051013_mdu.sv
// RV64 M-extension multiply/divide unit. Radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, with a final
// sign-fix cycle. Divide-by-zero and signed overflow finish after one cycle.
// Ports: clk, rst (sync, active-high); in_valid/in_ready request handshake with
//        funct3, word, op1, op2; flush aborts; out_valid/out_ready/result
//        response; busy = not idle.
// Build option: YSYX_22051013_MDU_ZERO_SKIP_EN finishes multiplies with a zero
//        operand after one cycle.
module ysyx_22051013_mdu
  import ysyx_22051013_mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            word,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  mdu_state_e        r_state, w_state_nxt;
  mdu_req_t          r_req;
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc, r_mcand;
  logic [XLEN-1:0]   r_mplier, r_rem, r_quo, r_divisor;
  logic [XLEN-1:0]   r_result;
  logic              r_in_ready, r_out_valid, r_busy;

  // Request-side operand conditioning, used to seed the datapath on accept
  logic            w_accept;
  logic [XLEN-1:0] w_in_a_mag, w_in_b_mag;

  assign w_accept   = (r_state == S_IDLE) && in_valid && !flush;
  assign w_in_a_mag = mag(ext_op(op1, op1_signed(funct3), word), op1_signed(funct3));
  assign w_in_b_mag = mag(ext_op(op2, op2_signed(funct3), word), op2_signed(funct3));

  // Latched-request decode for special cases and sign fix
  logic            w_a_sgn, w_b_sgn;
  logic [XLEN-1:0] w_a_ext, w_b_ext;
  logic            w_last, w_div_zero, w_div_ovf, w_div_special;

  assign w_a_sgn       = op1_signed(r_req.funct3);
  assign w_b_sgn       = op2_signed(r_req.funct3);
  assign w_a_ext       = ext_op(r_req.op1, w_a_sgn, r_req.word);
  assign w_b_ext       = ext_op(r_req.op2, w_b_sgn, r_req.word);
  assign w_last        = r_cnt == (r_req.word ? ITER_W : ITER_D);
  assign w_div_zero    = w_b_ext == '0;
  assign w_div_ovf     = w_a_sgn && (w_b_ext == '1) &&
                         (w_a_ext == (r_req.word ? 64'hFFFF_FFFF_8000_0000
                                                 : 64'h8000_0000_0000_0000));
  assign w_div_special = w_div_zero || w_div_ovf;

`ifdef YSYX_22051013_MDU_ZERO_SKIP_EN
  logic w_mul_zero;
  assign w_mul_zero = (w_a_ext == '0) || (w_b_ext == '0);
`endif

  // Iteration datapath
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [XLEN-1:0]   w_rem_nxt;
  logic              w_q_bit;

  assign w_acc_nxt = r_mplier[0] ? r_acc + r_mcand : r_acc;

  ysyx_22051013_div_iter u_div_iter (
    .i_rem     (r_rem),
    .i_bit     (r_quo[XLEN-1]),
    .i_divisor (r_divisor),
    .o_rem_c   (w_rem_nxt),
    .o_q_c     (w_q_bit)
  );

  // Sign fix and result selection
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res, w_quo_s, w_rem_s, w_div_res64, w_div_res;
  logic [XLEN-1:0]   w_dividend, w_div_spec_res, w_result_nxt;

  assign w_prod      = ((w_a_sgn & w_a_ext[XLEN-1]) ^ (w_b_sgn & w_b_ext[XLEN-1]))
                       ? (2*XLEN)'(-r_acc) : r_acc;
  assign w_mul_res   = r_req.word ? sext32(w_prod[HLEN-1:0])
                     : (r_req.funct3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  assign w_quo_s     = (w_a_sgn & (w_a_ext[XLEN-1] ^ w_b_ext[XLEN-1])) ? XLEN'(-r_quo) : r_quo;
  assign w_rem_s     = (w_a_sgn & w_a_ext[XLEN-1]) ? XLEN'(-r_rem) : r_rem;
  assign w_div_res64 = r_req.funct3[1] ? w_rem_s : w_quo_s;
  assign w_div_res   = r_req.word ? sext32(w_div_res64[HLEN-1:0]) : w_div_res64;
  assign w_dividend  = r_req.word ? sext32(r_req.op1[HLEN-1:0]) : r_req.op1;
  // rem: x/0 -> x, overflow -> 0; quo: x/0 -> all-ones, overflow -> x
  assign w_div_spec_res = r_req.funct3[1] ? (w_div_zero ? w_dividend : '0)
                                          : (w_div_zero ? '1 : w_dividend);

  always_comb begin
    w_result_nxt = r_result;
    if (r_state == S_MUL) begin
      w_result_nxt = w_mul_res;
`ifdef YSYX_22051013_MDU_ZERO_SKIP_EN
      if ((r_cnt == '0) && w_mul_zero) w_result_nxt = '0;
`endif
    end else if (r_state == S_DIV) begin
      w_result_nxt = ((r_cnt == '0) && w_div_special) ? w_div_spec_res : w_div_res;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = funct3[2] ? S_DIV : S_MUL;
      S_MUL: begin
        if (w_last) w_state_nxt = S_DONE;
`ifdef YSYX_22051013_MDU_ZERO_SKIP_EN
        else if ((r_cnt == '0) && w_mul_zero) w_state_nxt = S_DONE;
`endif
      end
      S_DIV:  if (w_last || ((r_cnt == '0) && w_div_special)) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // State register and registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_state_nxt == S_IDLE;
      r_out_valid <= w_state_nxt == S_DONE;
      r_busy      <= w_state_nxt != S_IDLE;
    end
  end

  // Datapath: seed on accept, one iteration per cycle until the count is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req     <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
    end else begin
      if (w_accept) begin
        r_req     <= '{funct3: funct3, word: word, op1: op1, op2: op2};
        r_cnt     <= '0;
        r_acc     <= '0;
        r_mcand   <= {{XLEN{1'b0}}, w_in_b_mag};
        r_mplier  <= w_in_a_mag;
        r_rem     <= '0;
        // Word divides start with the low word left-aligned so its MSB goes first
        r_quo     <= word ? {w_in_a_mag[HLEN-1:0], {(XLEN-HLEN){1'b0}}} : w_in_a_mag;
        r_divisor <= w_in_b_mag;
      end else if ((r_state == S_MUL) && !w_last) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
        r_cnt    <= r_cnt + CNT_W'(1);
      end else if ((r_state == S_DIV) && !w_last) begin
        r_rem <= w_rem_nxt;
        r_quo <= {r_quo[XLEN-2:0], w_q_bit};
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_state != S_DONE) && (w_state_nxt == S_DONE)) r_result <= w_result_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign result    = r_result;

endmodule

// File: tb/tb_ysyx_22051013_mdu.sv
// Self-checking bench for ysyx_22051013_mdu: directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_ysyx_22051013_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, word = 1'b0, flush = 1'b0;
  logic        out_valid, out_ready = 1'b0, busy;
  logic [2:0]  funct3 = 3'b000;
  logic [63:0] op1 = '0, op2 = '0, result;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  ysyx_22051013_mdu dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .word(word), .op1(op1), .op2(op2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Reference result from plain arithmetic on the architectural definition
  function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic        as, bs, sd;
    logic [63:0] ae, be, q64, r64;
    logic [31:0] q32, r32;
    logic [127:0] a128, b128, p;
    if (!f3[2]) begin
      as = (f3 != 3'b011);
      bs = (f3 == 3'b000) || (f3 == 3'b001);
      ae = w ? (as ? sx(a[31:0]) : {32'b0, a[31:0]}) : a;
      be = w ? (bs ? sx(b[31:0]) : {32'b0, b[31:0]}) : b;
      a128 = as ? {{64{ae[63]}}, ae} : {64'b0, ae};
      b128 = bs ? {{64{be[63]}}, be} : {64'b0, be};
      p = a128 * b128;
      if (f3 == 3'b000) return w ? sx(p[31:0]) : p[63:0];
      return p[127:64];
    end
    sd = !f3[0];
    if (w) begin
      if (b[31:0] == 32'd0) begin q32 = '1; r32 = a[31:0]; end
      else if (sd && a[31:0] == 32'h8000_0000 && b[31:0] == '1) begin q32 = a[31:0]; r32 = '0; end
      else if (sd) begin q32 = $signed(a[31:0]) / $signed(b[31:0]); r32 = $signed(a[31:0]) % $signed(b[31:0]); end
      else begin q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0]; end
      return sx(f3[1] ? r32 : q32);
    end
    if (b == 64'd0) begin q64 = '1; r64 = a; end
    else if (sd && a == 64'h8000_0000_0000_0000 && b == '1) begin q64 = a; r64 = '0; end
    else if (sd) begin q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b); end
    else begin q64 = a / b; r64 = a % b; end
    return f3[1] ? r64 : q64;
  endfunction

  // Expected cycles from accept to out_valid
  function automatic int exp_lat(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic zb, ovf;
    zb  = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf = !f3[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                       : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (f3[2] && (zb || ovf)) return 1;
`ifdef YSYX_22051013_MDU_ZERO_SKIP_EN
    if (!f3[2] && (w ? (a[31:0] == 0 || b[31:0] == 0) : (a == 0 || b == 0))) return 1;
`endif
    return w ? 33 : 65;
  endfunction

  // Issue one request, check latency and result, optionally stall out_ready
  task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input int hold);
    logic [63:0] er;
    int el, cyc;
    er = model(f3, w, a, b);
    el = exp_lat(f3, w, a, b);
    chk({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    funct3 = f3; word = w; op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom};
    cyc = 0;
    while (!out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk({tag, "/latency"}, 64'(cyc), 64'(el));
    chk({tag, "/result"}, result, er);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "/hold_result"}, result, er);
      chk({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "/hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "/drain_valid"}, 64'(out_valid), 64'd0);
  endtask

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [2:0] rf;
    logic rw;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst/in_ready", 64'(in_ready), 64'd1);
    chk("rst/out_valid", 64'(out_valid), 64'd0);
    chk("rst/busy", 64'(busy), 64'd0);
    chk("rst/result", result, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed corners
    run_op("mul_7_m3", 3'b000, 1'b0, 64'd7, -64'sd3, 0);
    chk("mul_7_m3/const", result, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op("divw_ovf", 3'b100, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0);
    chk("divw_ovf/const", result, 64'hFFFF_FFFF_8000_0000);
    run_op("remw_ovf", 3'b110, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 0);
    run_op("divu_zero", 3'b101, 1'b0, 64'd100, 64'd0, 0);
    chk("divu_zero/const", result, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("remu_zero", 3'b111, 1'b0, 64'd100, 64'd0, 0);
    chk("remu_zero/const", result, 64'd100);
    run_op("remw_zero_neg", 3'b110, 1'b1, 64'h1234_5678_F000_0001, 64'hABCD_0000_0000_0000, 0);
    run_op("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
    run_op("div_neg", 3'b100, 1'b0, -64'sd100, 64'd7, 0);
    run_op("rem_neg", 3'b110, 1'b0, -64'sd100, 64'd7, 0);
    run_op("mulw", 3'b000, 1'b1, 64'h0000_0001_7FFF_FFFF, 64'h0000_0000_0000_0003, 0);
    run_op("mulhsu", 3'b010, 1'b0, -64'sd2, '1, 0);
    run_op("mul_zero", 3'b000, 1'b0, 64'd0, 64'd12345, 0);
    run_op("mulhu_ones", 3'b011, 1'b0, '1, '1, 5);
    chk("mulhu_ones/const", result, 64'hFFFF_FFFF_FFFF_FFFE);

    // Reset in the middle of a multiply
    chk("rstmid/in_ready0", 64'(in_ready), 64'd1);
    funct3 = 3'b000; word = 1'b0; op1 = 64'd9; op2 = 64'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    chk("rstmid/busy_before", 64'(busy), 64'd1);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rstmid/busy", 64'(busy), 64'd0);
    chk("rstmid/out_valid", 64'(out_valid), 64'd0);
    chk("rstmid/result", result, 64'd0);
    chk("rstmid/in_ready", 64'(in_ready), 64'd1);

    // Flush a divide at cycle 10, then accept a new request straight away
    funct3 = 3'b100; word = 1'b0; op1 = 64'd1000; op2 = 64'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      chk("flush/no_valid", 64'(out_valid), 64'd0);
    end
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush/busy", 64'(busy), 64'd0);
    chk("flush/in_ready", 64'(in_ready), 64'd1);
    chk("flush/out_valid", 64'(out_valid), 64'd0);
    run_op("after_flush", 3'b101, 1'b0, 64'd1000, 64'd7, 0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      if (rw && (rf == 3'b001 || rf == 3'b010 || rf == 3'b011)) rw = 1'b0;
      run_op($sformatf("rnd%0d_f%0d_w%0d", i, rf, rw), rf, rw, rand_op(), rand_op(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
